// File: rtl/softmax_normalize.sv
// Softmax normalisation stage: buffers N clamped exponentials, sums them, then
// emits each element divided by the sum using a fixed-latency restoring divider.
module softmax_normalize #(
    parameter int WIDTH             = 16,
    parameter int FIXED_POINT_INDEX = 8,
    parameter int N                 = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    out_err,
    input  logic                    out_ready,
    output logic                    busy
);

    localparam int FRAC      = FIXED_POINT_INDEX;
    localparam int SUM_WIDTH = WIDTH + $clog2(N);
    localparam int REM_W     = SUM_WIDTH + 1;
    localparam int QW        = FRAC + 1;
    localparam int IDX_W     = $clog2(N);
    localparam int CNT_W     = $clog2(FRAC + 1);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_DIVIDE = 2'd1,
        S_OUTPUT = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]     elem_q [N];
    logic [WIDTH-1:0]     elem_d [N];
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     k_q, k_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [REM_W-1:0]     rem_q, rem_d;
    logic [QW-1:0]        quo_q, quo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;
    logic                 out_err_q, out_err_d;

    logic                 accept;
    logic                 last_idx;
    logic                 last_k;
    logic                 sum_zero;
    logic [WIDTH-1:0]     in_clamped;
    logic                 rem_ge;
    logic [REM_W-1:0]     rem_sub;
    logic [QW-1:0]        q_full;

    // A negative exp value can only come from a wrapped upstream result.
    function automatic logic [WIDTH-1:0] clamp_neg(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? '0 : x;
    endfunction

    function automatic logic [REM_W-1:0] div_step(input logic [REM_W-1:0] rem,
                                                  input logic [SUM_WIDTH-1:0] den,
                                                  input logic ge);
        logic [REM_W-1:0] r;
        r = ge ? rem - {1'b0, den} : rem;
        return r;
    endfunction

    assign accept     = in_valid && in_ready;
    assign last_idx   = (idx_q == IDX_W'(N - 1));
    assign last_k     = (k_q == IDX_W'(N - 1));
    assign sum_zero   = (sum_q == '0);
    assign in_clamped = clamp_neg(in_data);
    assign rem_ge     = (rem_q >= {1'b0, sum_q});
    assign rem_sub    = div_step(rem_q, sum_q, rem_ge);
    assign q_full     = {quo_q[QW-2:0], rem_ge};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:   if (accept && last_idx) state_d = S_DIVIDE;
            S_DIVIDE: if (cnt_q == '0) state_d = S_OUTPUT;
            S_OUTPUT: if (out_ready) state_d = out_last_q ? S_LOAD : S_DIVIDE;
            default:  state_d = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_LOAD);
        busy      = (state_q != S_LOAD) || (idx_q != '0);
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_last  = out_last_q;
        out_err   = out_err_q;
    end

    // Load stage, one restoring-divide iteration per cycle, output hold.
    always_comb begin
        elem_d      = elem_q;
        idx_d       = idx_q;
        k_d         = k_q;
        sum_d       = sum_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    elem_d[idx_q] = in_clamped;
                    sum_d         = sum_q + SUM_WIDTH'(in_clamped);
                    if (last_idx) begin
                        idx_d = '0;
                        k_d   = '0;
                        rem_d = REM_W'(elem_q[0]);
                        cnt_d = CNT_W'(FRAC);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DIVIDE: begin
                rem_d = rem_sub << 1;
                quo_d = q_full;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    out_valid_d = 1'b1;
                    out_err_d   = sum_zero;
                    out_data_d  = sum_zero ? '0 : WIDTH'(q_full);
                    out_last_d  = last_k;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        sum_d      = '0;
                        out_last_d = 1'b0;
                        out_err_d  = 1'b0;
                    end else begin
                        k_d   = k_q + IDX_W'(1);
                        rem_d = REM_W'(elem_q[k_q + IDX_W'(1)]);
                        cnt_d = CNT_W'(FRAC);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) elem_q[i] <= '0;
            idx_q       <= '0;
            k_q         <= '0;
            sum_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            elem_q      <= elem_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            sum_q       <= sum_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule
